// File: rtl/fft2d_pkg.sv
// Shared definitions for the 2D FFT sequencer: state/stage encoding and address sizing.
package fft2d_pkg;

    localparam logic [2:0] STAGE_IDLE   = 3'd0;
    localparam logic [2:0] STAGE_LOAD   = 3'd1;
    localparam logic [2:0] STAGE_ROW    = 3'd2;
    localparam logic [2:0] STAGE_COL    = 3'd3;
    localparam logic [2:0] STAGE_UNLOAD = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = STAGE_IDLE,
        ST_LOAD   = STAGE_LOAD,
        ST_ROW    = STAGE_ROW,
        ST_COL    = STAGE_COL,
        ST_UNLOAD = STAGE_UNLOAD
    } state_e;

    // One index bit per frame word plus the region bit on top.
    function automatic int unsigned addr_width(input int unsigned npoint, input int unsigned lanes);
        return $clog2(npoint * npoint / lanes) + 1;
    endfunction

endpackage

// File: rtl/fft2d_addr_perm.sv
// Combinational address generation: region selection per stage and the column-order permutation T(b).
module fft2d_addr_perm
    import fft2d_pkg::*;
#(
    parameter  int unsigned NPoint    = 16,
    parameter  int unsigned Lanes     = 4,
    localparam int unsigned AddrWidth = addr_width(NPoint, Lanes),
    localparam int unsigned IdxWidth  = AddrWidth - 1
) (
    input  state_e                i_state,
    input  logic                  i_mode1d,
    input  logic [IdxWidth-1:0]   i_rd_beat,
    input  logic [IdxWidth-1:0]   i_wr_beat,
    output logic [AddrWidth-1:0]  o_rd_addr,
    output logic [AddrWidth-1:0]  o_wr_addr
);

    function automatic logic [IdxWidth-1:0] transpose(input logic [IdxWidth-1:0] b);
        int unsigned bi;
        int unsigned t;
        bi = 32'(b);
        t  = (bi % NPoint) * (NPoint / Lanes) + bi / NPoint;
        return IdxWidth'(t);
    endfunction

    always_comb begin
        o_rd_addr = '0;
        o_wr_addr = '0;
        case (i_state)
            ST_LOAD: begin
                o_wr_addr = {1'b0, i_wr_beat};
            end
            ST_ROW: begin
                o_rd_addr = {1'b0, i_rd_beat};
                o_wr_addr = {1'b1, i_wr_beat};
            end
            // Column pass reads region 1 transposed and writes back into region 0.
            ST_COL: begin
                o_rd_addr = {1'b1, transpose(i_rd_beat)};
                o_wr_addr = {1'b0, transpose(i_wr_beat)};
            end
            ST_UNLOAD: begin
                o_rd_addr = {i_mode1d, i_rd_beat};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fft2d_seq.sv
// 2D FFT frame sequencer: LOAD -> ROW -> COL -> UNLOAD over a two-region SRAM.
// Optional FFT2D_MODE1D_EN adds mode_1d_i to skip the column pass.
module fft2d_seq
    import fft2d_pkg::*;
#(
    parameter  int unsigned NPoint    = 16,
    parameter  int unsigned Lanes     = 4,
    localparam int unsigned W         = NPoint * NPoint / Lanes,
    localparam int unsigned AddrWidth = addr_width(NPoint, Lanes)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
`ifdef FFT2D_MODE1D_EN
    input  logic                 mode_1d_i,
`endif
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 mdc_start_o,
    input  logic                 mdc_rdy_i,
    output logic [Lanes-1:0]     wen_o,
    output logic [AddrWidth-1:0] wr_addr_o,
    output logic                 ren_o,
    output logic [AddrWidth-1:0] rd_addr_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic [2:0]           stage_o,
    output logic                 frame_done_o
);

    localparam int unsigned          IdxWidth = AddrWidth - 1;
    localparam logic [AddrWidth-1:0] LastBeat = AddrWidth'(W - 1);
    localparam logic [AddrWidth-1:0] WordCnt  = AddrWidth'(W);
    localparam logic [AddrWidth-1:0] One      = AddrWidth'(1);

    state_e               r_state;
    logic [AddrWidth-1:0] r_cnt;
    logic [AddrWidth-1:0] r_wb_cnt;
    logic                 r_wb_active;
    logic                 r_ovalid;
    logic                 r_done;

    logic                 w_mode1d;
    logic                 w_pass;
    logic                 w_in_fire;
    logic                 w_wb_start;
    logic                 w_wb_fire;
    logic                 w_wb_last;
    logic                 w_out_fire;
    logic                 w_out_last;
    state_e               w_pass_next;
    logic [AddrWidth-1:0] w_wb_beat;
    logic [IdxWidth-1:0]  w_rd_beat;
    logic [IdxWidth-1:0]  w_wr_beat;
    logic [AddrWidth-1:0] w_rd_addr;
    logic [AddrWidth-1:0] w_wr_addr;

`ifdef FFT2D_MODE1D_EN
    logic r_mode1d;
    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            r_mode1d <= 1'b0;
        end else if (r_state == ST_IDLE && start_i) begin
            r_mode1d <= mode_1d_i;
        end
    end
    assign w_mode1d = r_mode1d;
`else
    assign w_mode1d = 1'b0;
`endif

    assign w_pass      = (r_state == ST_ROW) || (r_state == ST_COL);
    assign w_in_fire   = (r_state == ST_LOAD) && in_valid_i;
    // Engine output is written from the very cycle mdc_rdy_i is seen; later pulses are ignored.
    assign w_wb_start  = w_pass && !r_wb_active && mdc_rdy_i;
    assign w_wb_fire   = r_wb_active || w_wb_start;
    assign w_wb_beat   = r_wb_active ? r_wb_cnt : '0;
    assign w_wb_last   = w_wb_fire && (w_wb_beat == LastBeat);
    assign w_out_fire  = (r_state == ST_UNLOAD) && r_ovalid && out_ready_i;
    assign w_out_last  = w_out_fire && (r_cnt == LastBeat);
    assign w_pass_next = (r_state == ST_COL || w_mode1d) ? ST_UNLOAD : ST_COL;

    // Unload reads one beat ahead of the presented beat only once that beat is accepted.
    assign w_rd_beat = (r_state == ST_UNLOAD) ? IdxWidth'(r_cnt + AddrWidth'(w_out_fire))
                                              : IdxWidth'(r_cnt);
    assign w_wr_beat = (r_state == ST_LOAD) ? IdxWidth'(r_cnt) : IdxWidth'(w_wb_beat);

    fft2d_addr_perm #(
        .NPoint (NPoint),
        .Lanes  (Lanes)
    ) u_addr_perm (
        .i_state   (r_state),
        .i_mode1d  (w_mode1d),
        .i_rd_beat (w_rd_beat),
        .i_wr_beat (w_wr_beat),
        .o_rd_addr (w_rd_addr),
        .o_wr_addr (w_wr_addr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_wb_cnt    <= '0;
            r_wb_active <= 1'b0;
            r_ovalid    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_in_fire) begin
                        if (r_cnt == LastBeat) begin
                            r_state <= ST_ROW;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + One;
                        end
                    end
                end
                ST_ROW, ST_COL: begin
                    if (r_cnt != WordCnt) begin
                        r_cnt <= r_cnt + One;
                    end
                    if (w_wb_last) begin
                        r_state     <= w_pass_next;
                        r_cnt       <= '0;
                        r_wb_cnt    <= '0;
                        r_wb_active <= 1'b0;
                    end else if (w_wb_fire) begin
                        r_wb_active <= 1'b1;
                        r_wb_cnt    <= w_wb_beat + One;
                    end
                end
                ST_UNLOAD: begin
                    if (!r_ovalid) begin
                        r_ovalid <= 1'b1;
                    end else if (w_out_last) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        r_ovalid <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (w_out_fire) begin
                        r_cnt <= r_cnt + One;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ren_o        = (w_pass && (r_cnt != WordCnt)) || ((r_state == ST_UNLOAD) && !w_out_last);
    assign rd_addr_o    = ren_o ? w_rd_addr : '0;
    assign wen_o        = (w_in_fire || w_wb_fire) ? '1 : '0;
    assign wr_addr_o    = (w_in_fire || w_wb_fire) ? w_wr_addr : '0;
    assign mdc_start_o  = w_pass && (r_cnt == '0);
    assign in_ready_o   = (r_state == ST_LOAD);
    assign out_valid_o  = r_ovalid;
    assign busy_o       = (r_state != ST_IDLE);
    assign stage_o      = r_state;
    assign frame_done_o = r_done;

endmodule

// File: tb/tb_fft2d_seq.sv
// Scoreboard bench for fft2d_seq (NPoint=16, Lanes=4, W=64); covers FFT2D_MODE1D_EN when defined.
module tb_fft2d_seq;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       in_valid = 1'b0;
    logic       mdc_rdy = 1'b0;
    logic       out_ready = 1'b0;
`ifdef FFT2D_MODE1D_EN
    logic       mode_1d = 1'b0;
`endif
    logic       in_ready_o, mdc_start_o, ren_o, out_valid_o, busy_o, frame_done_o;
    logic [3:0] wen_o;
    logic [6:0] wr_addr_o, rd_addr_o;
    logic [2:0] stage_o;

    int n_vec = 0;
    int n_bad = 0;
    int q_wr[$];
    int q_rd[$];
    int q_mdc[$];
    int q_done[$];
    int mon_acc = 0;

    always #5 clk = ~clk;

    fft2d_seq #(.NPoint(16), .Lanes(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
`ifdef FFT2D_MODE1D_EN
        .mode_1d_i    (mode_1d),
`endif
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready_o),
        .mdc_start_o  (mdc_start_o),
        .mdc_rdy_i    (mdc_rdy),
        .wen_o        (wen_o),
        .wr_addr_o    (wr_addr_o),
        .ren_o        (ren_o),
        .rd_addr_o    (rd_addr_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready),
        .busy_o       (busy_o),
        .stage_o      (stage_o),
        .frame_done_o (frame_done_o)
    );

    function automatic int tcol(input int b);
        return (b % 16) * 4 + b / 16;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every DUT-presented event pops the scoreboard.
    always @(negedge clk) begin
        if (wen_o != 4'd0) begin
            if (q_wr.size() == 0) chk("wr_unexpected", int'(wr_addr_o), -1);
            else begin
                chk("wr_addr", int'(wr_addr_o), q_wr.pop_front());
                chk("wen_all", int'(wen_o), 15);
            end
        end
        if (ren_o) begin
            if (q_rd.size() == 0) chk("rd_unexpected", int'(rd_addr_o), -1);
            else chk("rd_addr", int'(rd_addr_o), q_rd.pop_front());
        end
        if (mdc_start_o) begin
            if (q_mdc.size() == 0) chk("mdc_unexpected", int'(rd_addr_o), -1);
            else chk("mdc_first_rd", int'(rd_addr_o), q_mdc.pop_front());
        end
        if (out_valid_o && out_ready) mon_acc++;
        if (frame_done_o) begin
            if (q_done.size() == 0) chk("done_unexpected", 1, 0);
            else begin
                void'(q_done.pop_front());
                chk("done_after_beats", mon_acc, 64);
            end
            mon_acc = 0;
        end else if (stage_o != 3'd4) begin
            mon_acc = 0;
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_stage"}, int'(stage_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_in_ready"}, int'(in_ready_o), 0);
        chk({tag, "_out_valid"}, int'(out_valid_o), 0);
        chk({tag, "_mdc_start"}, int'(mdc_start_o), 0);
        chk({tag, "_wen"}, int'(wen_o), 0);
        chk({tag, "_ren"}, int'(ren_o), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr_o), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr_o), 0);
        chk({tag, "_frame_done"}, int'(frame_done_o), 0);
    endtask

    task automatic wait_stage(input int st, input int bound);
        int k = 0;
        while (int'(stage_o) != st && k < bound) begin
            tick();
            k++;
        end
        chk("stage_reach", int'(stage_o), st);
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("load_stage", int'(stage_o), 1);
        chk("load_busy", int'(busy_o), 1);
        chk("load_in_ready", int'(in_ready_o), 1);
    endtask

    task automatic load_beats(input int n, input int gap_at);
        for (int b = 0; b < n; b++) begin
            if (b == gap_at) begin
                in_valid = 1'b0;
                mdc_rdy  = 1'b1;
                tick();
                mdc_rdy  = 1'b0;
            end
            in_valid = 1'b1;
            q_wr.push_back(b);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic row_pass(input int rdy_at, input bit extras, input int next_st);
        chk("row_entry", int'(stage_o), 2);
        for (int b = 0; b < 64; b++) q_rd.push_back(b);
        q_mdc.push_back(0);
        for (int c = 0; c < rdy_at; c++) begin
            start_i = extras && (c == 2);
            tick();
            start_i = 1'b0;
            if (extras && c == 2) chk("start_ignored_in_row", int'(stage_o), 2);
        end
        mdc_rdy = 1'b1;
        for (int b = 0; b < 64; b++) q_wr.push_back(64 + b);
        tick();
        mdc_rdy = 1'b0;
        if (extras) begin
            repeat (10) tick();
            mdc_rdy = 1'b1;
            tick();
            mdc_rdy = 1'b0;
        end
        wait_stage(next_st, 200);
    endtask

    task automatic col_pass(input int rdy_at);
        chk("col_entry", int'(stage_o), 3);
        for (int b = 0; b < 64; b++) q_rd.push_back(64 + tcol(b));
        q_mdc.push_back(64);
        repeat (rdy_at) tick();
        mdc_rdy = 1'b1;
        for (int b = 0; b < 64; b++) q_wr.push_back(tcol(b));
        tick();
        mdc_rdy = 1'b0;
        wait_stage(4, 200);
    endtask

    task automatic unload(input int base, input int stall_at, input int stall_n);
        int acc = 0;
        int stall = stall_n;
        int k = 0;
        chk("unload_entry", int'(stage_o), 4);
        for (int i = 0; i < 64; i++) begin
            q_rd.push_back(base + i);
            if (i == stall_at)
                for (int s = 0; s < stall_n; s++) q_rd.push_back(base + i);
        end
        q_done.push_back(1);
        while (acc < 64 && k < 400) begin
            if (out_valid_o) begin
                if (acc == stall_at && stall > 0) begin
                    out_ready = 1'b0;
                    stall--;
                end else begin
                    out_ready = 1'b1;
                    acc++;
                end
            end else begin
                out_ready = 1'b0;
            end
            tick();
            k++;
        end
        out_ready = 1'b0;
        chk("unload_beats", acc, 64);
        chk("done_pulse", int'(frame_done_o), 1);
        chk("done_idle", int'(stage_o), 0);
        tick();
        chk("done_one_cycle", int'(frame_done_o), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        repeat (2) tick();
        rst_i = 1'b0;
        check_idle("reset");

        // Full 2D frame: input gap, stray engine pulses, start during ROW, output stall at beat 10.
        start_frame();
        load_beats(64, 5);
        row_pass(5, 1'b1, 3);
        col_pass(5);
        unload(0, 10, 3);

        // Abort during COL at read beat 20.
        start_frame();
        load_beats(64, -1);
        row_pass(3, 1'b0, 3);
        chk("col_entry_abort", int'(stage_o), 3);
        for (int b = 0; b <= 20; b++) q_rd.push_back(64 + tcol(b));
        q_mdc.push_back(64);
        for (int c = 0; c < 20; c++) begin
            if (c == 4) begin
                mdc_rdy = 1'b1;
                for (int b = 0; b <= 16; b++) q_wr.push_back(tcol(b));
            end
            tick();
            mdc_rdy = 1'b0;
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check_idle("abort");
        repeat (3) tick();

        // Clean LOAD after abort, then reset at beat 30.
        start_frame();
        load_beats(30, -1);
        in_valid = 1'b1;
        q_wr.push_back(30);
        rst_i = 1'b1;
        tick();
        check_idle("midrst");
        rst_i = 1'b0;
        in_valid = 1'b0;
        tick();

        // Recovery frame, no stall.
        start_frame();
        load_beats(64, -1);
        row_pass(6, 1'b0, 3);
        col_pass(2);
        unload(0, -1, 0);

`ifdef FFT2D_MODE1D_EN
        mode_1d = 1'b1;
        start_frame();
        mode_1d = 1'b0;
        load_beats(64, -1);
        row_pass(4, 1'b0, 4);
        unload(64, -1, 0);
`endif

        repeat (3) tick();
        chk("q_wr_drained", q_wr.size(), 0);
        chk("q_rd_drained", q_rd.size(), 0);
        chk("q_mdc_drained", q_mdc.size(), 0);
        chk("q_done_drained", q_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fft2d_seq.md
FFT2D_SEQ -- requirements
Module: fft2d_seq

Interface
REQ-001 SHALL have parameter NPoint, default 16, meaning points per dimension (power of 4, 16..256).
REQ-002 SHALL have parameter Lanes, default 4, meaning samples per SRAM word and per engine beat (power of 2, at most NPoint).
REQ-003 SHALL derive W = NPoint*NPoint/Lanes words per frame and AddrWidth = log2(W)+1, where the MSB is the region bit.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i (in, 1) and rst_i (in, 1), all state updated on the rising edge of clk_i.
REQ-005 start_i  in  1  request a new frame; honoured only in IDLE.
REQ-006 abort_i  in  1  synchronous return to IDLE from any state.
REQ-007 in_valid_i  in  1, and in_ready_o  out  1: input beat handshake.
REQ-008 mdc_start_o  out  1, a one-cycle pulse that starts the radix-4 engine; mdc_rdy_i  in  1 marks the engine's first output beat.
REQ-009 wen_o  out  Lanes  per-lane write enable; wr_addr_o  out  AddrWidth  write address.
REQ-010 ren_o  out  1  read enable; rd_addr_o  out  AddrWidth  read address.
REQ-011 out_valid_o  out  1, and out_ready_i  in  1: output beat handshake.
REQ-012 busy_o  out  1, stage_o  out  3, frame_done_o  out  1: status outputs.

Function
REQ-013 SHALL implement the states IDLE(0), LOAD(1), ROW(2), COL(3) and UNLOAD(4), with stage_o equal to the state code.
REQ-014 IDLE->LOAD SHALL occur on start_i; start_i SHALL be ignored outside IDLE; busy_o SHALL equal (state != IDLE).
REQ-015 LOAD SHALL drive in_ready_o=1 and, on each in_valid_i&in_ready_o, set wen_o all-ones with wr_addr_o={0,b}, where b is the beat counter; after W beats it SHALL go to ROW.
REQ-016 ROW SHALL issue ren_o for W consecutive cycles with rd_addr_o={0,b}, and SHALL assert mdc_start_o in the same cycle as the first read.
REQ-017 Each pass write-back SHALL start in the cycle mdc_rdy_i is seen: W contiguous beats, wen_o all-ones, wr_addr_o={1,b} for ROW and {0,T(b)} for COL; mdc_rdy_i outside a write-back window SHALL be ignored.
REQ-018 T(b) SHALL be (b mod NPoint)*(NPoint/Lanes) + (b div NPoint) (column order); COL SHALL read {1,T(b)} and SHALL otherwise behave as ROW.
REQ-019 A pass SHALL end after its final write-back beat; ROW->COL, COL->UNLOAD.
REQ-020 UNLOAD SHALL read {0,b}; out_valid_o SHALL assert one cycle after a read is issued; while out_valid_o&~out_ready_i, rd_addr_o and b SHALL hold and ren_o SHALL stay high (re-read).
REQ-021 After the final accepted output beat, frame_done_o SHALL pulse for 1 cycle and the state SHALL become IDLE.
REQ-022 In one cycle, abort_i SHALL override start_i and all handshakes and SHALL clear counters; it SHALL produce no frame_done_o.
REQ-023 Counters SHALL be log2(W)+1 bits wide and SHALL never wrap silently; the terminal count is detected as b==W-1 with a handshake.

Reset
REQ-024 Under rst_i, the state SHALL be IDLE, all counters 0, and all outputs 0, including in_ready_o, out_valid_o, mdc_start_o and wen_o.
REQ-025 rst_i asserted mid-frame SHALL discard the frame, with outputs at reset values the cycle after.

Configuration
REQ-026 With FFT2D_MODE1D_EN defined, the block SHALL add input mode_1d_i (sampled at start_i); when it is set, ROW->UNLOAD skips COL and UNLOAD reads region 1.
REQ-027 Without FFT2D_MODE1D_EN, the port SHALL be absent and every frame SHALL be 2D.

Structure
REQ-028 A shared package fft2d_pkg SHALL hold the state enum, the stage codes and the address-width function.
REQ-029 A single sub-module, fft2d_addr_perm, SHALL be combinational and implement T(b) and region selection.

Verification (NPoint=16, Lanes=4, W=64)
REQ-030 start_i, then 64 in_valid_i beats -> wr_addr_o runs 0..63, then ROW, with mdc_start_o once, coinciding with rd_addr_o=0.
REQ-031 mdc_rdy_i 5 cycles after ROW start -> ROW writes {1,0..63}; COL reads 64,68,72,...,124,65,... (T(1)=4, T(16)=1).
REQ-032 UNLOAD with out_ready_i low for 3 cycles at beat 10 -> rd_addr_o holds 10, no beat lost, frame_done_o after beat 63.
REQ-033 abort_i in COL at beat 20 -> IDLE next cycle, busy_o=0, no frame_done_o; the next start_i begins a clean LOAD.
REQ-034 start_i during ROW -> ignored; rst_i at LOAD beat 30 -> all outputs 0, stage_o=0.
REQ-035 FFT2D_MODE1D_EN with mode_1d_i=1 -> no COL stage and UNLOAD reads addresses 64..127.
